// File: rtl/fetch_stage.sv
// fetch_stage: rv32 fetch PC, credit-limited imem requests, in-order response FIFO
// feeding decode, and redirect flush of buffered and in-flight fetches.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out,
   output logic        valid_out
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [31:0]   pc_q, pc_d, resp_pc_q, resp_pc_d, target;
   logic [CW-1:0] count_q, count_d, inflight_q, inflight_d, drop_q, drop_d;
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW:0]   used;
   logic [63:0]   mem_q [DEPTH];
   logic          hs, push, pop, dropping;

   always_comb begin
      target         = redirect_pc & 32'hFFFF_FFFC;
      used           = {1'b0, inflight_q} + {1'b0, count_q};
      // gating with rst_n keeps the request low while reset is held
      imem_req_valid = rst_n && !redirect && (used < DEPTH_C);
      imem_addr      = pc_q;
      hs             = imem_req_valid && imem_req_ready;
      dropping       = drop_q != '0;
      push           = imem_resp_valid && !dropping && !redirect;
      valid_out      = count_q != '0;
      pop            = valid_out && !stall && !redirect;
      {pc_out, instr_out} = valid_out ? mem_q[rd_q] : {32'h0, NOP};
      pc_d       = redirect ? target : hs ? pc_q + 32'd4 : pc_q;
      resp_pc_d  = redirect ? target : push ? resp_pc_q + 32'd4 : resp_pc_q;
      inflight_d = inflight_q + CW'(hs) - CW'(imem_resp_valid);
      drop_d     = redirect ? inflight_q - CW'(imem_resp_valid)
                            : drop_q - CW'(imem_resp_valid && dropping);
      count_d    = redirect ? '0 : count_q + CW'(push) - CW'(pop);
      wr_d       = redirect ? '0 : wr_q + AW'(push);
      rd_d       = redirect ? '0 : rd_q + AW'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC;
         resp_pc_q  <= RESET_PC;
         count_q    <= '0;
         inflight_q <= '0;
         drop_q     <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         pc_q       <= pc_d;
         resp_pc_q  <= resp_pc_d;
         count_q    <= count_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q] <= {resp_pc_q, imem_resp_data};
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed checks of fetch_stage against a latency-configurable
// memory model returning the address as data, plus an in-order PC scoreboard.
module tb_fetch_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 0, rst_n = 0, stall = 0, redirect = 0;
   logic [31:0] redirect_pc = 0;
   logic        imem_req_valid, imem_req_ready = 1, imem_resp_valid = 0;
   logic [31:0] imem_addr, imem_resp_data = 0, instr_out, pc_out;
   logic        valid_out;

   int n_cmp = 0, n_err = 0;
   int cyc = 0, lat = 1;
   bit toggle = 0;
   typedef struct packed { int due; logic [31:0] addr; } req_t;
   req_t q[$];
   logic [31:0] exp_pc = 0, prev_addr = 0, mark;
   logic        prev_wait = 0;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req_valid(imem_req_valid),
      .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .instr_out(instr_out), .pc_out(pc_out), .valid_out(valid_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // memory drives response and ready just after each rising edge
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         q.delete();
         imem_resp_valid = 0;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
         imem_resp_valid = 1;
         imem_resp_data  = q[0].addr;
         void'(q.pop_front());
      end else imem_resp_valid = 0;
      imem_req_ready = toggle ? cyc[0] : 1'b1;
   end

   always @(negedge clk) begin
      if (rst_n && imem_req_valid && imem_req_ready) q.push_back('{cyc + lat, imem_addr});
      if (rst_n) chk("max_inflight", 32'(q.size() <= 2), 1);
   end

   // in-order scoreboard and request-address stability
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc    = 32'h0;
         prev_wait = 0;
      end else begin
         if (prev_wait) chk("addr_stable", imem_addr, prev_addr);
         prev_wait = imem_req_valid && !imem_req_ready;
         prev_addr = imem_addr;
         if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
         else if (valid_out && !stall) begin
            chk("stream_pc", pc_out, exp_pc);
            chk("stream_instr", instr_out, exp_pc);
            exp_pc += 4;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      smp();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_instr", instr_out, NOP);
      chk("rst_pc_out", pc_out, 32'h0);
      tick(); tick(); rst_n = 1;
      smp();
      chk("n0_req_valid", imem_req_valid, 1);
      chk("n0_addr", imem_addr, 32'h0);
      chk("n0_valid_out", valid_out, 0);
      tick(); smp();
      chk("n1_valid_out", valid_out, 0);
      chk("n1_req_valid", imem_req_valid, 1);
      chk("n1_addr", imem_addr, 32'h4);
      tick(); smp();
      chk("n2_valid_out", valid_out, 1);
      chk("n2_pc_out", pc_out, 32'h0);
      chk("n2_instr", instr_out, 32'h0);
      tick(); smp();
      chk("n3_valid_out", valid_out, 1);
      chk("n3_pc_out", pc_out, 32'h4);
      repeat (6) begin tick(); smp(); end

      tick(); stall = 1;
      for (int i = 0; i < 4; i++) begin smp(); tick(); end
      smp();
      chk("stall_full_req", imem_req_valid, 0);
      chk("stall_full_valid", valid_out, 1);
      tick(); stall = 0;
      repeat (8) begin smp(); tick(); end
      smp();

      tick(); stall = 1;
      repeat (3) begin smp(); tick(); end
      redirect = 1; redirect_pc = 32'h100;
      smp();
      chk("r1_fifo_full", valid_out, 1);
      chk("r1_req_valid", imem_req_valid, 0);
      tick(); redirect = 0; stall = 0;
      smp();
      chk("r1p1_valid_out", valid_out, 0);
      chk("r1p1_req_valid", imem_req_valid, 1);
      chk("r1p1_addr", imem_addr, 32'h100);
      tick(); smp();
      chk("r1p2_valid_out", valid_out, 0);
      tick(); smp();
      chk("r1p3_valid_out", valid_out, 1);
      chk("r1p3_pc_out", pc_out, 32'h100);
      chk("r1p3_instr", instr_out, 32'h100);
      repeat (4) begin tick(); smp(); end

      tick(); redirect = 1; redirect_pc = 32'h203;
      smp();
      tick(); redirect = 0;
      smp();
      chk("r2p1_valid_out", valid_out, 0);
      chk("r2p1_addr", imem_addr, 32'h200);
      chk("r2p1_req_valid", imem_req_valid, 1);
      tick(); smp();
      tick(); smp();
      chk("r2p3_valid_out", valid_out, 1);
      chk("r2p3_pc_out", pc_out, 32'h200);
      repeat (3) begin tick(); smp(); end

      tick(); lat = 3; toggle = 1;
      mark = exp_pc;
      repeat (30) begin smp(); tick(); end
      smp();
      chk("lat3_progress", 32'(exp_pc >= mark + 32'h10), 1);
      tick(); redirect = 1; redirect_pc = 32'h300;
      smp();
      tick(); redirect = 0;
      smp();
      chk("r3p1_valid_out", valid_out, 0);
      chk("r3p1_addr", imem_addr, 32'h300);
      repeat (25) begin tick(); smp(); end
      chk("r3_progress", 32'(exp_pc >= 32'h308), 1);

      tick(); lat = 1; toggle = 0; stall = 1;
      repeat (4) begin smp(); tick(); end
      smp();
      chk("prerst_valid", valid_out, 1);
      @(posedge clk); #3; rst_n = 0; #1;
      chk("async_rst_valid_out", valid_out, 0);
      chk("async_rst_req_valid", imem_req_valid, 0);
      chk("async_rst_addr", imem_addr, 32'h0);
      chk("async_rst_instr", instr_out, NOP);
      tick(); tick(); rst_n = 1; stall = 0;
      smp();
      chk("rel_req_valid", imem_req_valid, 1);
      chk("rel_addr", imem_addr, 32'h0);
      tick(); smp();
      tick(); smp();
      chk("rel_valid_out", valid_out, 1);
      chk("rel_pc_out", pc_out, 32'h0);
      repeat (6) begin tick(); smp(); end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
